// File: rtl/csel_acc_pkg.sv
// Shared types and widths for the streaming carry-select accumulator.
package csel_acc_pkg;

  localparam int unsigned CSEL_W = 22;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ACCUM = 2'd1,
    HOLD  = 2'd2
  } state_t;

endpackage

// File: rtl/C_Sel_A_22bit.sv
// 22-bit carry-select adder: 4-bit ripple low block, then three 6-bit blocks
// that each precompute both carry-in cases and select on the incoming carry.
module C_Sel_A_22bit
  import csel_acc_pkg::*;
(
  input  logic [CSEL_W-1:0] A,
  input  logic [CSEL_W-1:0] B,
  input  logic              cin,
  output logic [CSEL_W-1:0] S,
  output logic              cout
);

  localparam int unsigned LO_W  = 4;
  localparam int unsigned BLK_W = 6;
  localparam int unsigned NBLK  = 3;

  logic [NBLK:0] c;

  assign {c[0], S[LO_W-1:0]} = (LO_W+1)'(A[LO_W-1:0]) + (LO_W+1)'(B[LO_W-1:0])
                             + (LO_W+1)'(cin);

  for (genvar k = 0; k < NBLK; k++) begin : g_blk
    localparam int unsigned OFF = LO_W + k * BLK_W;
    logic [BLK_W:0] s0;
    logic [BLK_W:0] s1;

    assign s0 = (BLK_W+1)'(A[OFF +: BLK_W]) + (BLK_W+1)'(B[OFF +: BLK_W]);
    assign s1 = (BLK_W+1)'(A[OFF +: BLK_W]) + (BLK_W+1)'(B[OFF +: BLK_W])
              + (BLK_W+1)'(1);
    assign {c[k+1], S[OFF +: BLK_W]} = c[k] ? s1 : s0;
  end

  assign cout = c[NBLK];

endmodule

// File: rtl/csel_accum_22bit.sv
// Streaming accumulator: sums operand beats through the carry-select adder and
// presents total, sticky overflow and beat count once the last beat is taken.
module csel_accum_22bit
  import csel_acc_pkg::*;
#(
  parameter int unsigned WIDTH = 22,
  parameter int unsigned CNT_W = 8,
  parameter bit          SAT   = 1'b0
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clr,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_data,
  input  logic             in_last,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_sum,
  output logic             out_ovf,
  output logic [CNT_W-1:0] out_cnt
);

  state_t           state_q, state_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic             ovf_q, ovf_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             vld_q, vld_d;
  logic [WIDTH-1:0] add_s;
  logic             add_cout;
  logic             accept;

  C_Sel_A_22bit u_add (
    .A    (in_data),
    .B    (acc_q),
    .cin  (1'b0),
    .S    (add_s),
    .cout (add_cout)
  );

  assign in_ready = !clr && (state_q != HOLD);
  assign accept   = in_valid && in_ready;

  // Next-state and datapath update; clr overrides everything.
  always_comb begin
    state_d = state_q;
    acc_d   = acc_q;
    ovf_d   = ovf_q;
    cnt_d   = cnt_q;
    vld_d   = vld_q;
    if (clr) begin
      state_d = IDLE;
      acc_d   = '0;
      ovf_d   = 1'b0;
      cnt_d   = '0;
      vld_d   = 1'b0;
    end else begin
      case (state_q)
        IDLE, ACCUM: begin
          if (accept) begin
            acc_d   = (SAT && add_cout) ? '1 : add_s;
            ovf_d   = ovf_q | add_cout;
            cnt_d   = (cnt_q == '1) ? cnt_q : cnt_q + CNT_W'(1);
            state_d = in_last ? HOLD : ACCUM;
            vld_d   = in_last;
          end
        end
        HOLD: begin
          if (out_ready) begin
            state_d = IDLE;
            acc_d   = '0;
            ovf_d   = 1'b0;
            cnt_d   = '0;
            vld_d   = 1'b0;
          end
        end
        default: begin
          state_d = IDLE;
          acc_d   = '0;
          ovf_d   = 1'b0;
          cnt_d   = '0;
          vld_d   = 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
      acc_q   <= '0;
      ovf_q   <= 1'b0;
      cnt_q   <= '0;
      vld_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      acc_q   <= acc_d;
      ovf_q   <= ovf_d;
      cnt_q   <= cnt_d;
      vld_q   <= vld_d;
    end
  end

  assign out_valid = vld_q;
  assign out_sum   = acc_q;
  assign out_ovf   = ovf_q;
  assign out_cnt   = cnt_q;

endmodule

// File: tb/tb_csel_accum_22bit.sv
// Directed bench: three lockstep instances (wrap, saturate, 2-bit counter) share stimulus.
module tb_csel_accum_22bit;

  logic        clk = 1'b0;
  logic        rst_n, clr, in_valid, in_last, out_ready;
  logic [21:0] in_data;

  logic        rdy0, rdy1, rdy2, vld0, vld1, vld2, ovf0, ovf1, ovf2;
  logic [21:0] sum0, sum1, sum2;
  logic [7:0]  cnt0, cnt1;
  logic [1:0]  cnt2;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  csel_accum_22bit #(.WIDTH(22), .CNT_W(8), .SAT(1'b0)) d0 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy0),
    .in_data(in_data), .in_last(in_last), .out_valid(vld0), .out_ready(out_ready),
    .out_sum(sum0), .out_ovf(ovf0), .out_cnt(cnt0));

  csel_accum_22bit #(.WIDTH(22), .CNT_W(8), .SAT(1'b1)) d1 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy1),
    .in_data(in_data), .in_last(in_last), .out_valid(vld1), .out_ready(out_ready),
    .out_sum(sum1), .out_ovf(ovf1), .out_cnt(cnt1));

  csel_accum_22bit #(.WIDTH(22), .CNT_W(2), .SAT(1'b0)) d2 (
    .clk(clk), .rst_n(rst_n), .clr(clr), .in_valid(in_valid), .in_ready(rdy2),
    .in_data(in_data), .in_last(in_last), .out_valid(vld2), .out_ready(out_ready),
    .out_sum(sum2), .out_ovf(ovf2), .out_cnt(cnt2));

  // Present one beat at the falling edge, hold it until accepted, return 1 time unit after the accepting edge.
  task automatic send_beat(input logic [21:0] d, input logic l);
    int n;
    @(negedge clk);
    in_valid = 1'b1; in_data = d; in_last = l;
    n = 0;
    while (!rdy0 && n < 20) begin
      @(negedge clk);
      n++;
    end
    tests++; if (rdy0 !== 1'b1) begin fails++; $display("FAIL beat_ready_timeout: got %b want 1", rdy0); end
    @(posedge clk); #1;
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic drain();
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    rst_n = 1'b0; clr = 1'b0; in_valid = 1'b1; in_data = 22'd5; in_last = 1'b1; out_ready = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    tests++; if (vld0 !== 1'b0) begin fails++; $display("FAIL reset_valid: got %b want 0", vld0); end
    tests++; if (sum0 !== 22'd0) begin fails++; $display("FAIL reset_sum: got %h want 0", sum0); end
    tests++; if (cnt0 !== 8'd0) begin fails++; $display("FAIL reset_cnt: got %0d want 0", cnt0); end
    tests++; if (ovf0 !== 1'b0) begin fails++; $display("FAIL reset_ovf: got %b want 0", ovf0); end
    in_valid = 1'b0; in_last = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  task automatic test_basic_sum();
    send_beat(22'd3, 1'b0);
    send_beat(22'd5, 1'b0);
    tests++; if (vld0 !== 1'b0) begin fails++; $display("FAIL t1_valid_early: got %b want 0", vld0); end
    send_beat(22'd7, 1'b1);
    tests++; if (vld0 !== 1'b1) begin fails++; $display("FAIL t1_valid: got %b want 1", vld0); end
    tests++; if (sum0 !== 22'd15) begin fails++; $display("FAIL t1_sum: got %h want %h", sum0, 22'd15); end
    tests++; if (ovf0 !== 1'b0) begin fails++; $display("FAIL t1_ovf: got %b want 0", ovf0); end
    tests++; if (cnt0 !== 8'd3) begin fails++; $display("FAIL t1_cnt: got %0d want 3", cnt0); end
    tests++; if (rdy0 !== 1'b0) begin fails++; $display("FAIL t1_hold_ready: got %b want 0", rdy0); end
    drain();
    tests++; if (vld0 !== 1'b0) begin fails++; $display("FAIL t1_valid_drop: got %b want 0", vld0); end
    tests++; if (sum0 !== 22'd0) begin fails++; $display("FAIL t1_sum_clear: got %h want 0", sum0); end
  endtask

  task automatic test_wrap();
    send_beat(22'h3FFFFF, 1'b0);
    send_beat(22'h000002, 1'b1);
    tests++; if (sum0 !== 22'h000001) begin fails++; $display("FAIL t2_sum: got %h want %h", sum0, 22'h000001); end
    tests++; if (ovf0 !== 1'b1) begin fails++; $display("FAIL t2_ovf: got %b want 1", ovf0); end
    tests++; if (cnt0 !== 8'd2) begin fails++; $display("FAIL t2_cnt: got %0d want 2", cnt0); end
    tests++; if (sum1 !== 22'h3FFFFF) begin fails++; $display("FAIL t2_sat_sum: got %h want %h", sum1, 22'h3FFFFF); end
    drain();
  endtask

  task automatic test_saturate();
    send_beat(22'h300000, 1'b0);
    send_beat(22'h200000, 1'b0);
    send_beat(22'h000001, 1'b1);
    tests++; if (sum1 !== 22'h3FFFFF) begin fails++; $display("FAIL t3_sum: got %h want %h", sum1, 22'h3FFFFF); end
    tests++; if (ovf1 !== 1'b1) begin fails++; $display("FAIL t3_ovf: got %b want 1", ovf1); end
    tests++; if (cnt1 !== 8'd3) begin fails++; $display("FAIL t3_cnt: got %0d want 3", cnt1); end
    tests++; if (sum0 !== 22'h100001) begin fails++; $display("FAIL t3_wrap_sum: got %h want %h", sum0, 22'h100001); end
    tests++; if (ovf0 !== 1'b1) begin fails++; $display("FAIL t3_wrap_ovf: got %b want 1", ovf0); end
    drain();
  endtask

  task automatic test_backpressure();
    int bad;
    out_ready = 1'b0;
    send_beat(22'd9, 1'b1);
    bad = 0;
    repeat (5) begin
      @(posedge clk); #1;
      if (rdy0 !== 1'b0 || sum0 !== 22'd9 || vld0 !== 1'b1) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL t4_hold_stable: got %0d bad cycles want 0", bad); end
    out_ready = 1'b1;
    drain();
    tests++; if (vld0 !== 1'b0) begin fails++; $display("FAIL t4_release: got %b want 0", vld0); end
    tests++; if (sum0 !== 22'd0) begin fails++; $display("FAIL t4_acc_clear: got %h want 0", sum0); end
    send_beat(22'd1, 1'b1);
    tests++; if (sum0 !== 22'd1) begin fails++; $display("FAIL t4_next_group: got %h want 1", sum0); end
    drain();
  endtask

  task automatic test_clear();
    int bad;
    send_beat(22'd4, 1'b0);
    send_beat(22'd4, 1'b0);
    tests++; if (sum0 !== 22'd8) begin fails++; $display("FAIL t5_partial: got %h want 8", sum0); end
    @(negedge clk);
    in_valid = 1'b1; in_data = 22'd4; clr = 1'b1;
    #1;
    tests++; if (rdy0 !== 1'b0) begin fails++; $display("FAIL t5_clr_ready: got %b want 0", rdy0); end
    @(posedge clk); #1;
    clr = 1'b0; in_valid = 1'b0;
    tests++; if (sum0 !== 22'd0) begin fails++; $display("FAIL t5_acc: got %h want 0", sum0); end
    tests++; if (cnt0 !== 8'd0) begin fails++; $display("FAIL t5_cnt: got %0d want 0", cnt0); end
    bad = 0;
    repeat (3) begin
      @(posedge clk); #1;
      if (vld0 !== 1'b0) bad++;
    end
    tests++; if (bad !== 0) begin fails++; $display("FAIL t5_no_valid: got %0d bad cycles want 0", bad); end
    send_beat(22'd6, 1'b1);
    tests++; if (sum0 !== 22'd6) begin fails++; $display("FAIL t5_sum: got %h want 6", sum0); end
    tests++; if (cnt0 !== 8'd1) begin fails++; $display("FAIL t5_cnt2: got %0d want 1", cnt0); end
    drain();
  endtask

  task automatic test_cnt_sat_and_async_reset();
    for (int i = 0; i < 5; i++) send_beat(22'd1, (i == 4));
    tests++; if (cnt2 !== 2'd3) begin fails++; $display("FAIL t6_cnt_sat: got %0d want 3", cnt2); end
    tests++; if (sum2 !== 22'd5) begin fails++; $display("FAIL t6_sum: got %h want 5", sum2); end
    tests++; if (cnt0 !== 8'd5) begin fails++; $display("FAIL t6_cnt_wide: got %0d want 5", cnt0); end
    drain();
    send_beat(22'd2, 1'b0);
    send_beat(22'd3, 1'b1);
    @(negedge clk);
    #1 rst_n = 1'b0;
    #1;
    tests++; if (vld0 !== 1'b0) begin fails++; $display("FAIL t6_rst_valid: got %b want 0", vld0); end
    tests++; if (sum0 !== 22'd0) begin fails++; $display("FAIL t6_rst_sum: got %h want 0", sum0); end
    tests++; if (cnt2 !== 2'd0) begin fails++; $display("FAIL t6_rst_cnt: got %0d want 0", cnt2); end
    #1 rst_n = 1'b1;
    send_beat(22'd7, 1'b1);
    tests++; if (sum0 !== 22'd7) begin fails++; $display("FAIL t6_after_rst: got %h want 7", sum0); end
    tests++; if (cnt0 !== 8'd1) begin fails++; $display("FAIL t6_after_rst_cnt: got %0d want 1", cnt0); end
    drain();
  endtask

  initial begin
    test_reset();
    test_basic_sum();
    test_wrap();
    test_saturate();
    test_backpressure();
    test_clear();
    test_cnt_sat_and_async_reset();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
